// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_ctrl_pkg: shared state, immediate-select, opcode and trap-cause codes
// Rev 1.0
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_SB   = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_DMEM    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rv_opcode_class.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_opcode_class: combinational opcode classifier for the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       writes_rd,
  output logic       illegal
);

  always_comb begin
    imm_sel   = IMM_NONE;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        imm_sel   = IMM_I;
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        imm_sel   = IMM_I;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        imm_sel  = IMM_S;
        is_store = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel   = IMM_SB;
        is_branch = 1'b1;
      end
      OPC_LUI: begin
        imm_sel   = IMM_U;
        writes_rd = 1'b1;
      end
      OPC_OP, OPC_OP_32: writes_rd = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl: multi-cycle RV64I sequencer with timeout/illegal traps
// Rev 1.0
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic [31:0]      ir,
  output logic [2:0]       imm_sel,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [31:0]       NOP       = 32'h0000_0013;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic [2:0] w_imm_sel;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_writes_rd;
  logic       w_illegal;

  // ir is stable from DECODE until the next fetch ack, so classification stays valid
  rv_opcode_class u_opcode_class (
    .opcode    (ir[6:0]),
    .imm_sel   (w_imm_sel),
    .is_load   (w_is_load),
    .is_store  (w_is_store),
    .is_branch (w_is_branch),
    .writes_rd (w_writes_rd),
    .illegal   (w_illegal)
  );

  assign imem_req = (r_state == ST_FETCH) && !reset;
  assign dmem_req = (r_state == ST_MEM);
  assign dmem_we  = (r_state == ST_MEM) && w_is_store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_wait_cnt  <= '0;
      ir          <= NOP;
      imm_sel     <= IMM_NONE;
      alu_src_imm <= 1'b0;
      mem_to_reg  <= 1'b0;
      reg_we      <= 1'b0;
      pc_we       <= 1'b0;
      pc_sel_br   <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= TRAP_NONE;
      instret     <= '0;
    end else begin
      reg_we    <= 1'b0;
      pc_we     <= 1'b0;
      pc_sel_br <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir         <= imem_rdata;
            r_wait_cnt <= '0;
            r_state    <= ST_DECODE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            trap       <= 1'b1;
            trap_cause <= TRAP_IMEM;
            r_state    <= ST_TRAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          imm_sel     <= w_imm_sel;
          alu_src_imm <= (w_imm_sel != IMM_NONE);
          mem_to_reg  <= w_is_load;
          if (w_illegal) begin
            trap       <= 1'b1;
            trap_cause <= TRAP_ILLEGAL;
            r_state    <= ST_TRAP;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_wait_cnt <= '0;
          if (w_is_branch) begin
            pc_we     <= 1'b1;
            pc_sel_br <= br_taken;
            instret   <= instret + CNT_W'(1);
            r_state   <= ST_FETCH;
          end else if (w_is_load || w_is_store) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_wait_cnt <= '0;
            if (w_is_store) begin
              pc_we   <= 1'b1;
              instret <= instret + CNT_W'(1);
              r_state <= ST_FETCH;
            end else begin
              r_state <= ST_WB;
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            trap       <= 1'b1;
            trap_cause <= TRAP_DMEM;
            r_state    <= ST_TRAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB: begin
          reg_we  <= w_writes_rd;
          pc_we   <= 1'b1;
          instret <= instret + CNT_W'(1);
          r_state <= ST_FETCH;
        end
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rv_multicycle_ctrl: directed + random checks against a schedule-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SW   = 32'h0011_2423;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] LUI  = 32'h1234_50B7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          dmem_ack = 1'b0;
  logic          br_taken = 1'b0;
  logic          imem_req, alu_src_imm, dmem_req, dmem_we, mem_to_reg;
  logic          reg_we, pc_we, pc_sel_br, trap;
  logic [31:0]   ir;
  logic [2:0]    imm_sel;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(imem_req), .ir(ir),
    .imm_sel(imm_sel), .alu_src_imm(alu_src_imm), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .pc_we(pc_we),
    .pc_sel_br(pc_sel_br), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instruction, a fixed schedule of edges after the fetch ack,
  // interrupted only by the two handshake waits.
  typedef struct packed {
    logic [2:0] imm;
    logic load, store, branch, wr, bad;
  } cls_t;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    c = '0;
    case (op)
      7'b0000011:             begin c.imm = 3'd1; c.load = 1'b1; c.wr = 1'b1; end
      7'b0010011, 7'b0011011: begin c.imm = 3'd1; c.wr = 1'b1; end
      7'b0100011:             begin c.imm = 3'd2; c.store = 1'b1; end
      7'b1100011:             begin c.imm = 3'd3; c.branch = 1'b1; end
      7'b0110111:             begin c.imm = 3'd4; c.wr = 1'b1; end
      7'b0110011, 7'b0111011: c.wr = 1'b1;
      default:                c.bad = 1'b1;
    endcase
    return c;
  endfunction

  localparam int P_FETCH = 0, P_SEQ = 1, P_DATA = 2, P_HALT = 3;
  int          ph = P_FETCH;
  int          seq_n = 0;
  int          waited = 0;
  cls_t        cur = '0;
  logic [31:0] e_ir = 32'h13;
  logic [2:0]  e_imm = 3'd0;
  logic        e_alu = 1'b0, e_m2r = 1'b0, e_reg_we = 1'b0, e_pc_we = 1'b0;
  logic        e_sel = 1'b0, e_trap = 1'b0;
  logic [1:0]  e_cause = 2'd0;
  int unsigned e_ret = 0;

  task automatic retire(input logic taken);
    e_pc_we = 1'b1;
    e_sel   = taken;
    e_reg_we = cur.wr;
    e_ret++;
    ph = P_FETCH;
    waited = 0;
  endtask

  task automatic halt(input logic [1:0] cause);
    ph = P_HALT;
    e_trap = 1'b1;
    e_cause = cause;
  endtask

  task automatic model_step();
    e_reg_we = 1'b0;
    e_pc_we  = 1'b0;
    e_sel    = 1'b0;
    if (reset) begin
      ph = P_FETCH; waited = 0; seq_n = 0; cur = '0;
      e_ir = 32'h13; e_imm = 3'd0; e_alu = 1'b0; e_m2r = 1'b0;
      e_trap = 1'b0; e_cause = 2'd0; e_ret = 0;
    end else begin
      case (ph)
        P_FETCH: begin
          if (imem_ack) begin
            e_ir = imem_rdata;
            cur = classify(imem_rdata[6:0]);
            ph = P_SEQ; seq_n = 0; waited = 0;
          end else begin
            waited++;
            if (waited == TMO) halt(2'd2);
          end
        end
        P_SEQ: begin
          seq_n++;
          if (seq_n == 1) begin
            e_imm = cur.imm;
            e_alu = (cur.imm != 3'd0);
            e_m2r = cur.load;
            if (cur.bad) halt(2'd1);
          end else if (seq_n == 2) begin
            if (cur.branch) retire(br_taken);
            else if (cur.load || cur.store) begin ph = P_DATA; waited = 0; end
          end else begin
            retire(1'b0);
          end
        end
        P_DATA: begin
          if (dmem_ack) begin
            if (cur.store) retire(1'b0);
            else begin ph = P_SEQ; seq_n = 2; end
          end else begin
            waited++;
            if (waited == TMO) halt(2'd3);
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("ir", ir, e_ir);
    chk("imm_sel", 32'(imm_sel), 32'(e_imm));
    chk("alu_src_imm", 32'(alu_src_imm), 32'(e_alu));
    chk("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
    chk("reg_we", 32'(reg_we), 32'(e_reg_we));
    chk("pc_we", 32'(pc_we), 32'(e_pc_we));
    chk("pc_sel_br", 32'(pc_sel_br), 32'(e_sel));
    chk("trap", 32'(trap), 32'(e_trap));
    chk("trap_cause", 32'(trap_cause), 32'(e_cause));
    chk("instret", 32'(instret), 32'(e_ret % (1 << CW)));
    chk("imem_req", 32'(imem_req), 32'((ph == P_FETCH) && !reset));
    chk("dmem_req", 32'(dmem_req), 32'(ph == P_DATA));
    chk("dmem_we", 32'(dmem_we), 32'((ph == P_DATA) && cur.store));
  end

  task automatic step(input logic ia, input logic [31:0] rd, input logic da, input logic bt);
    imem_ack = ia; imem_rdata = rd; dmem_ack = da; br_taken = bt;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [6:0]  ops [8] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0110011, 7'b0111011};
  logic [31:0] r;
  logic [6:0]  op;
  int          k;

  initial begin
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_imm_sel", 32'(imm_sel), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);

    // ADDI, ack in the cycle req rises
    step(1'b1, ADDI, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("addi_imm_sel", 32'(imm_sel), 32'd1);
    chk("addi_alu_src", 32'(alu_src_imm), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("addi_reg_we", 32'(reg_we), 32'd1);
    chk("addi_instret", 32'(instret), 32'd1);

    // SW with 3 data wait cycles
    step(1'b1, SW, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sw_imm_sel", 32'(imm_sel), 32'd2);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sw_dmem_we_first", 32'(dmem_we), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sw_dmem_we_fourth", 32'(dmem_we), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sw_dmem_req_drop", 32'(dmem_req), 32'd0);
    chk("sw_pc_we", 32'(pc_we), 32'd1);
    chk("sw_no_reg_we", 32'(reg_we), 32'd0);
    chk("sw_instret", 32'(instret), 32'd2);

    // BEQ taken then not taken
    step(1'b1, BEQ, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("beq_imm_sel", 32'(imm_sel), 32'd3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("beq_taken_sel", 32'(pc_sel_br), 32'd1);
    chk("beq_instret", 32'(instret), 32'd3);
    step(1'b1, BEQ, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("beq_nt_sel", 32'(pc_sel_br), 32'd0);
    chk("beq_nt_pc_we", 32'(pc_we), 32'd1);
    chk("beq_nt_instret", 32'(instret), 32'd4);

    // JAL is illegal here
    step(1'b1, JAL, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("jal_trap", 32'(trap), 32'd1);
    chk("jal_cause", 32'(trap_cause), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, ADDI, 1'b1, 1'b0);
    chk("jal_late_ack_ir", ir, JAL);
    chk("jal_no_retire", 32'(instret), 32'd4);
    chk("jal_no_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    #1;
    chk("jal_reset_trap", 32'(trap), 32'd0);
    chk("jal_reset_cause", 32'(trap_cause), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // fetch timeout on the 4th wait cycle
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("tmo_not_yet", 32'(trap), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("tmo_trap", 32'(trap), 32'd1);
    chk("tmo_cause", 32'(trap_cause), 32'd2);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, ADDI, 1'b0, 1'b0);
    chk("tmo_ack_wins", 32'(trap), 32'd0);
    chk("tmo_ack_ir", ir, ADDI);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("tmo_ack_instret", 32'(instret), 32'd1);

    // reset in the middle of a load's data access
    step(1'b1, LW, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lw_dmem_req", 32'(dmem_req), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("lw_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("lw_rst_imem_req", 32'(imem_req), 32'd0);
    chk("lw_rst_ir", ir, 32'h0000_0013);
    chk("lw_rst_instret", 32'(instret), 32'd0);
    chk("lw_rst_m2r", 32'(mem_to_reg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("lui_fresh_req", 32'(imem_req), 32'd1);
    step(1'b1, LUI, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lui_imm_sel", 32'(imm_sel), 32'd4);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lui_reg_we", 32'(reg_we), 32'd1);
    chk("lui_instret", 32'(instret), 32'd1);

    // random traffic, with resets to leave traps and occasionally mid-flight
    for (int n = 0; n < 4000; n++) begin
      if ((ph == P_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        pulse_reset();
      r = $urandom();
      k = $urandom_range(0, 8);
      op = (k < 8) ? ops[k] : r[6:0];
      imem_rdata = {r[31:7], op};
      imem_ack = ($urandom_range(0, 3) != 0);
      dmem_ack = ($urandom_range(0, 2) != 0);
      br_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
